ifid_hazard_reg: RTL and testbench

- Receiving end of the IF stage output interface: captures IF's fetched instruction/PC into the IF/ID pipeline register.
- Detects load-use hazards against ID/EX and back-pressures IF.
- Kills wrong-path instructions when EX/MEM redirects the PC.
- Sits between IF and ID in the 5-stage RV32I pipeline; provides saturating stall/flush counters for performance runs.

---
 rtl/ifid_hazard_reg.sv | 154 +++++++++++++++
 tb/tb_ifid_hazard_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ifid_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection and redirect flush.
//
// Captures the instruction and PC that IF fetched into the IF/ID register.
// It stalls IF and bubbles ID/EX when the instruction in IF/ID reads the
// destination of a load that is still in ID/EX. A taken branch or jump that
// resolves in EX/MEM kills the wrong-path word. Saturating counters record
// stall cycles and redirect events.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   IF_d_inst, IF_d_pc    word fetched by IF this cycle and its PC
//   EXMEM_c_SelPC         taken redirect from EX/MEM (flush the wrong path)
//   IDEX_c_MemRead        ID/EX instruction is a load
//   IDEX_d_rd             destination register of the ID/EX instruction
//   IF_c_stall            IF holds its PC and presents the same word again
//   IDEX_c_bubble         ID/EX loads a NOP on the next edge
//   IFID_d_inst/pc/valid  registered instruction, PC and valid bit to ID
//   stall_cnt, flush_cnt  saturating performance counters
module ifid_hazard_reg #(
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IF_d_inst,
  input  logic [31:0]      IF_d_pc,
  input  logic             EXMEM_c_SelPC,
  input  logic             IDEX_c_MemRead,
  input  logic [4:0]       IDEX_d_rd,
  output logic             IF_c_stall,
  output logic             IDEX_c_bubble,
  output logic [31:0]      IFID_d_inst,
  output logic [31:0]      IFID_d_pc,
  output logic             IFID_c_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);
  // A redirect either returns straight to RUN or spends extra cycles in FLUSH
  localparam state_t     S_AFTER_REDIR = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;

  state_t           r_state, w_nxt;
  logic [31:0]      r_inst, r_pc;
  logic             r_valid;
  logic [1:0]       r_fcnt, w_fc_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic             w_ld_if, w_ld_nop, w_stall_inc, w_flush_inc;
  logic [6:0]       w_op;
  logic [4:0]       w_rs1, w_rs2;
  logic             w_uses_rs1, w_uses_rs2, w_hazard;

  // Hazard decode works on the registered word, i.e. the one ID is decoding
  assign w_op  = r_inst[6:0];
  assign w_rs1 = r_inst[19:15];
  assign w_rs2 = r_inst[24:20];

  assign w_uses_rs1 = !(w_op == 7'b0110111 || w_op == 7'b0010111 ||
                        w_op == 7'b1101111);
  assign w_uses_rs2 = (w_op == 7'b0110011 || w_op == 7'b0100011 ||
                       w_op == 7'b1100011);

  assign w_hazard = r_valid && IDEX_c_MemRead && (IDEX_d_rd != 5'd0) &&
                    ((w_uses_rs1 && IDEX_d_rd == w_rs1) ||
                     (w_uses_rs2 && IDEX_d_rd == w_rs2));

  always_comb begin
    w_nxt       = r_state;
    w_fc_nxt    = r_fcnt;
    w_ld_if     = 1'b0;
    w_ld_nop    = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EXMEM_c_SelPC) begin
          w_ld_nop    = 1'b1;
          w_fc_nxt    = FC_LOAD;
          w_flush_inc = 1'b1;
          w_nxt       = S_FLUSH;
        end else begin
          w_ld_if = 1'b1;
          w_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        // A redirect wins over a hazard: the stalled word is wrong-path anyway
        if (EXMEM_c_SelPC) begin
          w_ld_nop    = 1'b1;
          w_fc_nxt    = FC_LOAD;
          w_flush_inc = 1'b1;
          w_nxt       = S_AFTER_REDIR;
        end else if (w_hazard) begin
          w_stall_inc = 1'b1;
        end else begin
          w_ld_if = 1'b1;
        end
      end
      S_FLUSH: begin
        w_ld_nop = 1'b1;
        if (EXMEM_c_SelPC) begin
          w_fc_nxt    = FC_LOAD;
          w_flush_inc = 1'b1;
          w_nxt       = S_AFTER_REDIR;
        end else begin
          w_fc_nxt = (r_fcnt == 2'd0) ? 2'd0 : r_fcnt - 2'd1;
          if (r_fcnt <= 2'd1) w_nxt = S_RUN;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_inst      <= NOP_INST;
      r_pc        <= 32'd0;
      r_valid     <= 1'b0;
      r_fcnt      <= 2'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_fcnt  <= w_fc_nxt;
      if (w_ld_nop) begin
        // PC is left as-is; it is meaningless while valid is low
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end else if (w_ld_if) begin
        r_inst  <= IF_d_inst;
        r_pc    <= IF_d_pc;
        r_valid <= 1'b1;
      end
      if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Gated by rst so a stray SelPC during reset cannot bubble ID/EX
  assign IF_c_stall    = rst && (r_state == S_RUN) && w_hazard && !EXMEM_c_SelPC;
  assign IDEX_c_bubble = rst && (((r_state == S_RUN) && w_hazard) || EXMEM_c_SelPC);

  assign IFID_d_inst  = r_inst;
  assign IFID_d_pc    = r_pc;
  assign IFID_c_valid = r_valid;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_ifid_hazard_reg.sv
// Directed bench for ifid_hazard_reg. Inputs change on the falling edge;
// registered outputs are sampled 1 ns after the rising edge and
// combinational outputs 1 ns after the inputs change. Counters are built
// narrow (4 bits) so that saturation can be reached in a few cycles.
module tb_ifid_hazard_reg;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      IF_d_inst, IF_d_pc;
  logic             EXMEM_c_SelPC, IDEX_c_MemRead;
  logic [4:0]       IDEX_d_rd;
  logic             IF_c_stall, IDEX_c_bubble, IFID_c_valid;
  logic [31:0]      IFID_d_inst, IFID_d_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifid_hazard_reg #(.NOP_INST(NOP), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IF_d_inst(IF_d_inst), .IF_d_pc(IF_d_pc),
    .EXMEM_c_SelPC(EXMEM_c_SelPC), .IDEX_c_MemRead(IDEX_c_MemRead),
    .IDEX_d_rd(IDEX_d_rd),
    .IF_c_stall(IF_c_stall), .IDEX_c_bubble(IDEX_c_bubble),
    .IFID_d_inst(IFID_d_inst), .IFID_d_pc(IFID_d_pc),
    .IFID_c_valid(IFID_c_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with SelPC and a would-be hazard asserted: outputs must stay quiet
    rst = 1'b0; IF_d_inst = 32'h0050_0093; IF_d_pc = 32'd0;
    EXMEM_c_SelPC = 1'b1; IDEX_c_MemRead = 1'b1; IDEX_d_rd = 5'd1;
    #12;
    chk("rst_inst",   IFID_d_inst, NOP);
    chk("rst_pc",     IFID_d_pc, 32'd0);
    chk("rst_valid",  32'(IFID_c_valid), 32'd0);
    chk("rst_stall",  32'(IF_c_stall), 32'd0);
    chk("rst_bubble", 32'(IDEX_c_bubble), 32'd0);
    chk("rst_scnt",   32'(stall_cnt), 32'd0);
    chk("rst_fcnt",   32'(flush_cnt), 32'd0);
    #8;  // t=20
    rst = 1'b1; EXMEM_c_SelPC = 1'b0; IDEX_c_MemRead = 1'b0; IDEX_d_rd = 5'd0;

    // First edge out of reset captures the IF word
    post_edge();
    chk("cap_inst",  IFID_d_inst, 32'h0050_0093);
    chk("cap_pc",    IFID_d_pc, 32'd0);
    chk("cap_valid", 32'(IFID_c_valid), 32'd1);
    chk("cap_stall", 32'(IF_c_stall), 32'd0);

    // Load-use on rs1: add x3,x1,x2 vs load to x1
    @(negedge clk); IF_d_inst = 32'h0020_81B3; IF_d_pc = 32'd4;
    post_edge();
    chk("add_inst", IFID_d_inst, 32'h0020_81B3);
    @(negedge clk); IF_d_inst = 32'h0000_12B7; IF_d_pc = 32'd8;
    IDEX_c_MemRead = 1'b1; IDEX_d_rd = 5'd1;
    #1;
    chk("lu_stall",  32'(IF_c_stall), 32'd1);
    chk("lu_bubble", 32'(IDEX_c_bubble), 32'd1);
    post_edge();
    chk("lu_hold_inst", IFID_d_inst, 32'h0020_81B3);
    chk("lu_hold_pc",   IFID_d_pc, 32'd4);
    chk("lu_scnt",      32'(stall_cnt), 32'd1);
    @(negedge clk); IDEX_c_MemRead = 1'b0;
    #1;
    chk("lu_clear", 32'(IF_c_stall), 32'd0);
    post_edge();
    chk("lu_resume_inst", IFID_d_inst, 32'h0000_12B7);
    chk("lu_resume_pc",   IFID_d_pc, 32'd8);

    // LUI x5 reads no register: a load to x5 must not stall
    @(negedge clk); IDEX_c_MemRead = 1'b1; IDEX_d_rd = 5'd5;
    IF_d_inst = 32'h0000_0000; IF_d_pc = 32'hC;
    #1;
    chk("lui_nostall",  32'(IF_c_stall), 32'd0);
    chk("lui_nobubble", 32'(IDEX_c_bubble), 32'd0);
    post_edge();
    chk("lui_scnt", 32'(stall_cnt), 32'd1);

    // Redirect
    @(negedge clk); EXMEM_c_SelPC = 1'b1; IDEX_c_MemRead = 1'b0;
    IF_d_inst = 32'h00C0_0113; IF_d_pc = 32'd8;
    #1;
    chk("rd_bubble", 32'(IDEX_c_bubble), 32'd1);
    chk("rd_stall",  32'(IF_c_stall), 32'd0);
    post_edge();
    chk("rd_inst",  IFID_d_inst, NOP);
    chk("rd_valid", 32'(IFID_c_valid), 32'd0);
    chk("rd_fcnt",  32'(flush_cnt), 32'd1);
    @(negedge clk); EXMEM_c_SelPC = 1'b0;
    IF_d_inst = 32'h0020_81B3; IF_d_pc = 32'h40;
    post_edge();
    chk("tgt_inst",  IFID_d_inst, 32'h0020_81B3);
    chk("tgt_pc",    IFID_d_pc, 32'h40);
    chk("tgt_valid", 32'(IFID_c_valid), 32'd1);

    // Flush beats stall: rs2 hazard (x2) plus SelPC in the same cycle
    @(negedge clk); EXMEM_c_SelPC = 1'b1; IDEX_c_MemRead = 1'b1; IDEX_d_rd = 5'd2;
    #1;
    chk("fb_stall",  32'(IF_c_stall), 32'd0);
    chk("fb_bubble", 32'(IDEX_c_bubble), 32'd1);
    post_edge();
    chk("fb_inst",  IFID_d_inst, NOP);
    chk("fb_valid", 32'(IFID_c_valid), 32'd0);
    chk("fb_scnt",  32'(stall_cnt), 32'd1);
    chk("fb_fcnt",  32'(flush_cnt), 32'd2);

    // Async reset between edges while stalled
    @(negedge clk); EXMEM_c_SelPC = 1'b0; IDEX_c_MemRead = 1'b0;
    IF_d_inst = 32'h0020_81B3; IF_d_pc = 32'h50;
    post_edge();
    @(negedge clk); IDEX_c_MemRead = 1'b1; IDEX_d_rd = 5'd1;
    #1;
    chk("ar_pre_stall", 32'(IF_c_stall), 32'd1);
    #2; rst = 1'b0;
    #1;
    chk("ar_inst",   IFID_d_inst, NOP);
    chk("ar_pc",     IFID_d_pc, 32'd0);
    chk("ar_valid",  32'(IFID_c_valid), 32'd0);
    chk("ar_stall",  32'(IF_c_stall), 32'd0);
    chk("ar_bubble", 32'(IDEX_c_bubble), 32'd0);
    chk("ar_scnt",   32'(stall_cnt), 32'd0);
    chk("ar_fcnt",   32'(flush_cnt), 32'd0);
    @(negedge clk); rst = 1'b1; IDEX_c_MemRead = 1'b0;
    post_edge();
    chk("ar_recap_inst",  IFID_d_inst, 32'h0020_81B3);
    chk("ar_recap_valid", 32'(IFID_c_valid), 32'd1);

    // Stall counter saturation: hazard held for 20 cycles on a 4-bit counter
    @(negedge clk); IDEX_c_MemRead = 1'b1; IDEX_d_rd = 5'd2;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_scnt",  32'(stall_cnt), 32'd15);
    chk("sat_hold",  IFID_d_inst, 32'h0020_81B3);
    chk("sat_stall", 32'(IF_c_stall), 32'd1);

    // Flush counter saturation: SelPC held for 20 cycles
    @(negedge clk); IDEX_c_MemRead = 1'b0; EXMEM_c_SelPC = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_fcnt",   32'(flush_cnt), 32'd15);
    chk("sat_fvalid", 32'(IFID_c_valid), 32'd0);
    chk("sat_scnt2",  32'(stall_cnt), 32'd15);
    @(negedge clk); EXMEM_c_SelPC = 1'b0; IF_d_inst = 32'h00C0_0113; IF_d_pc = 32'h80;
    post_edge();
    chk("post_sat_inst",  IFID_d_inst, 32'h00C0_0113);
    chk("post_sat_valid", 32'(IFID_c_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the sequence above ever stalls on an event
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete, got t=%0t want < 100000", $time);
    $fatal(1);
  end
endmodule
